// File: rtl/mem_arbiter_llsc.sv
// Round-robin N-core memory arbiter with one outstanding backend transaction.
// A central LL/SC reservation table decides the outcome of each store-conditional.
module mem_arbiter_llsc #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RESV_LSB  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req_valid,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [NUM_CORES-1:0]        req_wr,
    input  logic [NUM_CORES-1:0]        req_atomic,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_sc_success,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_wr,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_wdata,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_rdata
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int TAG_W = ADDR_W - RESV_LSB;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic                 wr_q, wr_d;
    logic                 atomic_q, atomic_d;
    logic                 sc_ok_q, sc_ok_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_CORES-1:0] resv_vld_q, resv_vld_d;
    logic [TAG_W-1:0]     resv_tag_q [NUM_CORES];
    logic [TAG_W-1:0]     resv_tag_d [NUM_CORES];

    logic                 found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 sel_wr;
    logic                 sel_atomic;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [TAG_W-1:0]     sel_tag;
    logic [NUM_CORES-1:0] tag_hit;
    logic                 sc_pass;

    // First requester at or after rr_ptr, wrapping at NUM_CORES.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_CORES);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign sel_wr     = req_wr[gnt_idx];
    assign sel_atomic = req_atomic[gnt_idx];
    assign sel_addr   = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata  = req_wdata[gnt_idx*DATA_W +: DATA_W];
    assign sel_tag    = sel_addr[ADDR_W-1:RESV_LSB];

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            tag_hit[c] = resv_vld_q[c] && (resv_tag_q[c] == sel_tag);
        end
    end

    assign sc_pass = tag_hit[gnt_idx];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_d           = gnt_q;
        wr_d            = wr_q;
        atomic_d        = atomic_q;
        sc_ok_d         = sc_ok_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        resv_vld_d      = resv_vld_q;
        resv_tag_d      = resv_tag_q;
        req_ready       = '0;
        resp_valid      = '0;
        resp_rdata      = '0;
        resp_sc_success = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_wr      = 1'b0;
        mem_req_addr    = '0;
        mem_req_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    req_ready[gnt_idx] = 1'b1;
                    gnt_d    = gnt_idx;
                    wr_d     = sel_wr;
                    atomic_d = sel_atomic;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    sc_ok_d  = sel_wr && sel_atomic && sc_pass;
                    rr_ptr_d = IDX_W'((int'(gnt_idx) + 1) % NUM_CORES);
                    state_d  = ISSUE;
                    if (sel_atomic && !sel_wr) begin
                        resv_vld_d[gnt_idx] = 1'b1;
                        resv_tag_d[gnt_idx] = sel_tag;
                    end else if (sel_wr && sel_atomic && !sc_pass) begin
                        // Failed SC never reaches the backend.
                        resv_vld_d[gnt_idx] = 1'b0;
                        state_d             = RESP;
                    end else if (sel_wr) begin
                        resv_vld_d = resv_vld_q & ~tag_hit;
                    end
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_wr    = wr_q;
                mem_req_addr  = addr_q;
                mem_req_wdata = wdata_q;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                resp_rdata        = wr_q ? '0 : rdata_q;
                resp_sc_success   = wr_q && atomic_q && sc_ok_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            resv_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            resv_vld_q <= resv_vld_d;
        end
    end

    // NOTE: payload and reservation tags are not reset; they are only read while a state or valid bit qualifies them.
    always_ff @(posedge clk) begin
        gnt_q      <= gnt_d;
        wr_q       <= wr_d;
        atomic_q   <= atomic_d;
        sc_ok_q    <= sc_ok_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        rdata_q    <= rdata_d;
        resv_tag_q <= resv_tag_d;
    end

endmodule

// File: tb/tb_mem_arbiter_llsc.sv
// Directed and randomized bench for mem_arbiter_llsc against a transaction-level
// model of grant order, reservations and backend memory contents.
module tb_mem_arbiter_llsc;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_wr, req_atomic, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_rdata, mem_req_wdata, mem_resp_rdata;
    logic            resp_sc_success, mem_req_valid, mem_req_ready, mem_req_wr, mem_resp_valid;
    logic [AW-1:0]   mem_req_addr;

    logic [AW-1:0]   c_addr  [N];
    logic [DW-1:0]   c_wdata [N];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = c_addr[i];
            req_wdata[i*DW +: DW] = c_wdata[i];
        end
    end

    mem_arbiter_llsc #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RESV_LSB(RL)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wr          (req_wr),
        .req_atomic      (req_atomic),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_sc_success (resp_sc_success),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_wr      (mem_req_wr),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata)
    );

    // Reference model: next core to consider, reserved word per core, backend memory.
    int            m_rr;
    bit            m_on   [N];
    logic [AW-1:0] m_word [N];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            obs_grant;
    logic          obs_sc;
    logic [DW-1:0] obs_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_resp_sc"}, resp_sc_success, 0);
        check({tag, "_mem_valid"}, mem_req_valid, 0);
        check({tag, "_mem_wr"}, mem_req_wr, 0);
        check({tag, "_mem_addr"}, mem_req_addr, 0);
        check({tag, "_mem_wdata"}, mem_req_wdata, 0);
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int c = 0; c < N; c++) m_on[c] = 1'b0;
    endtask

    // Called at 1 time unit after an edge; returns at the same phase, DUT in IDLE.
    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = '0;
        req_wr         = '0;
        req_atomic     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        @(posedge clk); #4;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_req(input int c, input bit wr, input bit at, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd);
        req_valid[c]  = 1'b1;
        req_wr[c]     = wr;
        req_atomic[c] = at;
        c_addr[c]     = a;
        c_wdata[c]    = wd;
    endtask

    task automatic new_req(input int c);
        int op;
        op = $urandom_range(0, 3);
        set_req(c, (op == 1) || (op == 3), op >= 2,
                32'h200 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3), $urandom);
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return 0;
    endfunction

    // One complete transaction for whichever core the model says wins arbitration.
    task automatic serve(input int rdy_dly, input int rsp_dly, input bit rearm);
        int            g;
        int            budget;
        bit            is_wr, is_at, sc_pass, sc_fail;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        g      = pick();
        budget = 0;
        #3;
        while (req_ready == '0 && budget < 16) begin
            @(posedge clk); #4;
            budget++;
        end
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant = i;
        check("grant", req_ready, 64'd1 << g);
        check("accept_no_mem", mem_req_valid, 0);
        check("accept_no_resp", resp_valid, 0);

        is_wr   = req_wr[g];
        is_at   = req_atomic[g];
        a       = c_addr[g];
        wd      = c_wdata[g];
        sc_pass = m_on[g] && (m_word[g] == (a >> RL));
        sc_fail = is_wr && is_at && !sc_pass;
        if (!is_wr && is_at) begin
            m_on[g]   = 1'b1;
            m_word[g] = a >> RL;
        end else if (sc_fail) begin
            m_on[g] = 1'b0;
        end else if (is_wr) begin
            for (int c = 0; c < N; c++) if (m_word[c] == (a >> RL)) m_on[c] = 1'b0;
        end
        m_rr = (g + 1) % N;

        @(posedge clk); #1;
        if (rearm) new_req(g);
        else req_valid[g] = 1'b0;
        mem_req_ready = (rdy_dly == 0);
        #3;

        if (sc_fail) begin
            check("scfail_no_mem", mem_req_valid, 0);
            check("scfail_resp", resp_valid, 64'd1 << g);
            check("scfail_rdata", resp_rdata, 0);
            check("scfail_sc", resp_sc_success, 0);
        end else begin
            for (int k = 0; k <= rdy_dly; k++) begin
                if (k > 0) begin
                    @(posedge clk); #1;
                    mem_req_ready  = (k == rdy_dly);
                    mem_resp_valid = 1'($urandom_range(0, 1));
                    #3;
                end
                check("mem_valid", mem_req_valid, 1);
                check("mem_wr", mem_req_wr, is_wr);
                check("mem_addr", mem_req_addr, a);
                check("mem_wdata", mem_req_wdata, wd);
                check("issue_no_resp", resp_valid, 0);
            end
            if (is_wr) begin
                mem[a] = wd;
                rd     = $urandom;
            end else begin
                rd = mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
            end
            for (int k = 0; k <= rsp_dly; k++) begin
                @(posedge clk); #1;
                mem_req_ready  = 1'b0;
                mem_resp_valid = (k == rsp_dly);
                mem_resp_rdata = (k == rsp_dly) ? rd : $urandom;
                #3;
                check("wait_no_mem", mem_req_valid, 0);
                check("wait_no_resp", resp_valid, 0);
            end
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            #3;
            check("resp_valid", resp_valid, 64'd1 << g);
            check("resp_rdata", resp_rdata, is_wr ? 0 : rd);
            check("resp_sc", resp_sc_success, is_wr && is_at && sc_pass);
        end
        obs_sc    = resp_sc_success;
        obs_rdata = resp_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            c_addr[c]  = '0;
            c_wdata[c] = '0;
        end
        do_reset();

        // Single read through core 1.
        mem[32'h100] = 32'hDEAD_BEEF;
        set_req(1, 0, 0, 32'h100, 0);
        serve(0, 1, 0);
        check("t_read_grant", obs_grant, 1);
        check("t_read_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("t_read_sc", obs_sc, 0);

        // All cores requesting continuously: grant order 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < N; c++) new_req(c);
        for (int k = 0; k < 5; k++) begin
            serve($urandom_range(0, 2), $urandom_range(0, 2), k < 4);
            check("rr_order", obs_grant, k % N);
        end
        req_valid = '0;

        // LL/SC success.
        do_reset();
        set_req(0, 0, 1, 32'h200, 0);  serve(0, 0, 0);
        set_req(0, 1, 1, 32'h200, 5);  serve(0, 0, 0);
        check("llsc_ok", obs_sc, 1);
        check("llsc_ok_mem", mem[32'h200], 5);

        // Write to a different word keeps the reservation.
        set_req(0, 0, 1, 32'h200, 0);  serve(1, 0, 0);
        set_req(2, 1, 0, 32'h204, 9);  serve(0, 1, 0);
        set_req(0, 1, 1, 32'h200, 6);  serve(0, 0, 0);
        check("llsc_other_word", obs_sc, 1);

        // Write to the same word kills it.
        set_req(0, 0, 1, 32'h200, 0);  serve(0, 0, 0);
        set_req(2, 1, 0, 32'h200, 11); serve(0, 0, 0);
        set_req(0, 1, 1, 32'h200, 7);  serve(0, 0, 0);
        check("llsc_same_word", obs_sc, 0);
        check("llsc_same_word_mem", mem[32'h200], 11);

        // Competing SCs on one word.
        set_req(0, 0, 1, 32'h300, 0);  serve(0, 0, 0);
        set_req(1, 0, 1, 32'h300, 0);  serve(0, 0, 0);
        set_req(0, 1, 1, 32'h300, 21); serve(0, 0, 0);
        check("compete_first", obs_sc, 1);
        set_req(1, 1, 1, 32'h300, 22); serve(0, 0, 0);
        check("compete_second", obs_sc, 0);

        // Backend backpressure.
        set_req(2, 1, 0, 32'h500, 32'h1234); serve(5, 2, 0);
        set_req(3, 0, 0, 32'h500, 0);        serve(5, 0, 0);
        check("bp_readback", obs_rdata, 32'h1234);

        // Reset while waiting for the backend.
        set_req(1, 0, 1, 32'h400, 0);  serve(0, 0, 0);
        set_req(3, 0, 0, 32'h600, 0);
        #3;
        check("rstw_grant", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid[3]  = 1'b0;
        mem_req_ready = 1'b1;
        #3;
        check("rstw_issue", mem_req_valid, 1);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst           = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #3;
        check_idle_outputs("rstw");
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD0_0BAD;
        #3;
        check("rstw_stale_resp0", resp_valid, 0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        #3;
        check("rstw_stale_resp1", resp_valid, 0);
        @(posedge clk); #1;
        set_req(1, 1, 1, 32'h400, 7);  serve(0, 0, 0);
        check("rstw_resv_cleared", obs_sc, 0);

        // Random mix of cores, operations and backend delays.
        for (int t = 0; t < 120; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!req_valid[c] && $urandom_range(0, 1) == 1) new_req(c);
            end
            if (req_valid == '0) new_req($urandom_range(0, N - 1));
            serve($urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_llsc.md
Name: mem_arbiter_llsc

Overview:
- Parametrised N-core memory arbiter for the shared-L2 path of the multicore system.
- Takes the per-core memory request/response channels (valid, wr, addr, wdata, atomic → valid, rdata, sc_success), grants them round-robin, and serialises them onto one backend port.
- Owns the LL/SC reservation table that decides SC success centrally.
- Replaces the fixed two-core, direct-wired L1/L2 hookup with NUM_CORES channels and real arbitration.

Parameters:
- NUM_CORES, 4: number of requesting cores (≥2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- RESV_LSB, 2: low address bits ignored when matching reservations (2 = word granule).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CORES  per-core request valid.
- req_ready  out  NUM_CORES  per-core accept; one-hot pulse.
- req_wr  in  NUM_CORES  1 = write.
- req_atomic  in  NUM_CORES  with wr=0: LL; with wr=1: SC.
- req_addr  in  NUM_CORES*ADDR_W  core i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CORES*DATA_W  packed the same way.
- resp_valid  out  NUM_CORES  one-cycle response pulse to the owning core.
- resp_rdata  out  DATA_W  shared; valid when any resp_valid is high.
- resp_sc_success  out  1  SC result; 0 for non-SC responses.
- mem_req_valid  out  1  backend request valid.
- mem_req_ready  in  1  backend accept.
- mem_req_wr  out  1  backend write.
- mem_req_addr  out  ADDR_W  backend address.
- mem_req_wdata  out  DATA_W  backend write data.
- mem_resp_valid  in  1  backend completion; returned for both reads and writes.
- mem_resp_rdata  in  DATA_W  backend read data.

Behaviour:

Reset:
- All outputs 0.
- FSM = IDLE, rr_ptr = 0.
- Every reservation invalid.
- Reset mid-transaction abandons it; no resp_valid is issued.
- mem_resp_valid seen outside WAIT is ignored.

Transactions:
- One transaction outstanding at a time.
- FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Grant the first core with req_valid, searching upward from rr_ptr with wrap at NUM_CORES.
- Raise req_ready[g] for that cycle only; latch wr, atomic, addr, wdata and g.
- Set rr_ptr = (g+1) mod NUM_CORES.
- No requesters: stay in IDLE, rr_ptr unchanged.
- Reservation actions (below) take effect in this acceptance cycle.
- Next state: RESP for a failed SC, otherwise ISSUE.

ISSUE:
- Drive mem_req_* from the latched values.
- Hold mem_req_valid and all fields stable until mem_req_ready is high.
- Go to WAIT in the cycle after the handshake.

WAIT:
- On mem_resp_valid, capture mem_resp_rdata and go to RESP.
- Wait indefinitely otherwise.

RESP:
- resp_valid[g] = 1 for exactly one cycle.
- resp_rdata = captured data for reads/LL, 0 for writes and SC.
- resp_sc_success = 1 only for a successful SC.
- Return to IDLE; a new grant is possible in the following cycle.

Latency:
- Accept → mem_req_valid: 1 cycle.
- mem_resp_valid → resp_valid: 1 cycle.
- Failed SC: resp_valid 1 cycle after accept, with no backend access.

Reservations:
- One entry per core: valid bit plus tag = addr[ADDR_W-1:RESV_LSB].
- LL by core c: set resv[c] = {1, tag}, overwriting any previous reservation.
- SC by core c succeeds iff resv[c] is valid and the tags match.
  - Success: perform the write and invalidate every entry with a matching tag, including c's own.
  - Failure: invalidate resv[c] only.
- Plain write: invalidate every entry with a matching tag (all cores).
- Plain read: no reservation effect.

Fairness and protocol:
- A core granted this round cannot be granted again until every other requester has been considered.
- No starvation under continuous requests.
- A core must hold req_valid and its fields until req_ready.
- Cores not granted see req_ready = 0.

Test Plan:
- Single read, NUM_CORES=4: core1 reads 0x100; backend ready immediately and returns 0xDEADBEEF two cycles later → req_ready[1] in the accept cycle, mem_req_valid the next cycle, resp_valid[1] with rdata 0xDEADBEEF one cycle after mem_resp_valid, sc_success=0.
- Round-robin: all 4 cores request continuously → grant order 0,1,2,3,0; each core gets exactly one resp_valid per round.
- LL/SC success: core0 LL 0x200, then SC 0x200 with wdata 5 → backend write of 5 to 0x200, resp_sc_success=1.
- LL/SC conflict: core0 LL 0x200, core2 writes 0x204, core0 SC 0x200 → the SC succeeds (different word). Separately, core0 LL 0x200, core2 writes 0x200, core0 SC 0x200 → sc_success=0, no mem_req_valid for the SC, resp 1 cycle after accept.
- Competing SCs: core0 and core1 both LL 0x300, core0 SC wins → core1's subsequent SC to 0x300 fails.
- Backpressure/reset: mem_req_ready held low 5 cycles → mem_req_* stable throughout. Assert rst during WAIT → all outputs 0 next cycle, reservations cleared, and a later mem_resp_valid produces no resp_valid.
